// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage feeding decode. Holds the fetch PC, issues
//   word-aligned requests to instruction memory, buffers returned words in a
//   small FIFO and hands them to decode with a valid/ready handshake. A
//   redirect from decode flushes the FIFO and discards stale responses.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   imem_req_valid/ready, imem_addr request channel to instruction memory
//   imem_rsp_valid, imem_rsp_data   in-order response channel
//   PCSrc, jump_target              redirect pulse and target from decode
//   Instruction, PC_next            FIFO head word and its PC + 4
//   instr_valid, instr_ready        decode handshake
//   misalign_err                    one-cycle pulse on a misaligned target
module fetch_unit #(
  parameter int                 INSTRW     = 32,
  parameter int                 PCWIDTH    = 32,
  parameter int                 FIFO_DEPTH = 2,
  parameter logic [PCWIDTH-1:0] RESET_PC   = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PCWIDTH-1:0] imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTRW-1:0]  imem_rsp_data,
  input  logic               PCSrc,
  input  logic [PCWIDTH-1:0] jump_target,
  output logic [INSTRW-1:0]  Instruction,
  output logic [PCWIDTH-1:0] PC_next,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               misalign_err
);

  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);

  logic [PCWIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PCWIDTH-1:0] head_pc_q, head_pc_d;
  logic [PTRW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTRW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0]    count_q, count_d;
  logic [CNTW-1:0]    outst_q, outst_d;
  logic [CNTW-1:0]    drop_q, drop_d;
  logic               misalign_q, misalign_d;
  logic [INSTRW-1:0]  fifo_q [FIFO_DEPTH];

  logic [CNTW:0]      credit_used;
  logic               req_fire;
  logic               rsp_drop;
  logic               push;
  logic               pop;
  logic [PCWIDTH-1:0] target_aligned;

  // Credit rule: a request is only issued if its response is guaranteed a
  // FIFO slot, so the FIFO never needs backpressure on the response side.
  // rst_n gates the request so nothing is presented while held in reset.
  assign credit_used    = {1'b0, count_q} + {1'b0, outst_q};
  assign imem_req_valid = rst_n & ~PCSrc & (credit_used < (CNTW+1)'(FIFO_DEPTH));
  assign imem_addr      = fetch_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign target_aligned = {jump_target[PCWIDTH-1:2], 2'b00};

  assign instr_valid  = (count_q != '0);
  assign Instruction  = instr_valid ? fifo_q[rd_ptr_q] : '0;
  assign PC_next      = head_pc_q + PCWIDTH'(4);
  assign misalign_err = misalign_q;

  // A redirect flushes the FIFO, so neither a push nor a pop in that cycle
  // may touch it.
  assign rsp_drop = (drop_q != '0);
  assign push     = imem_rsp_valid & ~rsp_drop & ~PCSrc;
  assign pop      = instr_valid & instr_ready & ~PCSrc;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_pc_d  = head_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    drop_d     = drop_q;
    misalign_d = 1'b0;
    outst_d    = outst_q + CNTW'(req_fire) - CNTW'(imem_rsp_valid);

    if (PCSrc) begin
      fetch_pc_d = target_aligned;
      head_pc_d  = target_aligned;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      // Everything still in flight is stale; a response landing this cycle
      // is already being thrown away, so it is not counted again.
      drop_d     = outst_q - CNTW'(imem_rsp_valid);
      misalign_d = |jump_target[1:0];
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PCWIDTH'(4);
      if (imem_rsp_valid && rsp_drop) drop_d = drop_q - CNTW'(1);
      if (push) wr_ptr_d = wr_ptr_q + PTRW'(1);
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + PTRW'(1);
        head_pc_d = head_pc_q + PCWIDTH'(4);
      end
      count_d = count_q + CNTW'(push) - CNTW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      head_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      misalign_q <= misalign_d;
    end
  end

  // Storage needs no reset: the head is only observed while count_q != 0.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= imem_rsp_data;
  end

endmodule
